mac_vec_accum: RTL

- Parametrised successor to the single-purpose conv/FC multiply-accumulate unit.
- Computes a signed dot product of a runtime-programmable length (1..2^LEN_W terms), replacing the fixed 25/192 counts selected by layer code.
- Uses valid/ready handshakes on both sides and a 2-stage multiply/accumulate pipeline.
- Adds a requantised output: arithmetic right shift, optional ReLU and saturation. Sits between the weight/pixel fetch logic and the layer output buffer.

---
 rtl/mac_pkg.sv | 42 ++++
 rtl/mac_requant.sv | 31 +++
 rtl/mac_vec_accum.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types, default widths and the saturating clip helper for the MAC family.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int DATA_W_DEF  = 16;
    localparam int ACC_W_DEF   = 40;
    localparam int LEN_W_DEF   = 8;
    localparam int OUT_W_DEF   = 16;
    localparam int SHIFT_W_DEF = 5;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } clip_t;

    // Clip a sign-extended value into a signed field of the given width.
    function automatic clip_t sat_clip(input logic signed [63:0] value, input int unsigned width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        clip_t              r;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            r.value = max_v;
            r.sat   = 1'b1;
        end else if (value < min_v) begin
            r.value = min_v;
            r.sat   = 1'b1;
        end else begin
            r.value = value;
            r.sat   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_requant.sv
// Combinational requantiser: floor arithmetic shift, optional ReLU, signed saturation.
module mac_requant
    import mac_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic signed [ACC_W-1:0]   i_acc,
    input  logic        [SHIFT_W-1:0] i_shift,
    input  logic                      i_relu,
    output logic signed [OUT_W-1:0]   o_data,
    output logic                      o_sat
);

    logic signed [ACC_W-1:0] w_shifted;
    logic signed [ACC_W-1:0] w_relu;
    logic signed [63:0]      w_ext;
    clip_t                   w_clip;

    // Shift, rectify, widen to the helper's width and clip to the output range.
    always_comb begin
        w_shifted = i_acc >>> i_shift;
        w_relu    = (i_relu && (w_shifted < 0)) ? '0 : w_shifted;
        w_ext     = 64'(w_relu);
        w_clip    = sat_clip(w_ext, OUT_W);
        o_data    = OUT_W'(w_clip.value);
        o_sat     = w_clip.sat;
    end

endmodule

// File: rtl/mac_vec_accum.sv
// Signed dot-product engine with programmable length, 2-stage MAC pipeline,
// valid/ready on both sides and a requantised result.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | waiting for the first beat of a vector; cfg latched on accept
//  ST_ACCUM | accepting beats until the last one is taken
//  ST_FLUSH | last product folded into the sum, result registered
//  ST_HOLD  | result presented until out_ready
module mac_vec_accum
    import mac_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic        [LEN_W-1:0]   cfg_len,
    input  logic        [SHIFT_W-1:0] cfg_shift,
    input  logic                      cfg_relu,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_a,
    input  logic signed [DATA_W-1:0]  in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic signed [ACC_W-1:0]   out_acc,
    output logic                      out_sat,
    output logic                      busy
);

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic        [LEN_W-1:0]   r_count;
    logic        [LEN_W-1:0]   r_len;
    logic        [SHIFT_W-1:0] r_shift;
    logic                      r_relu;
    logic signed [2*DATA_W-1:0] r_prod;
    logic                      r_prod_vld;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_out_valid;
    logic signed [OUT_W-1:0]   r_out_data;
    logic signed [ACC_W-1:0]   r_out_acc;
    logic                      r_out_sat;

    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_clear;
    logic        [LEN_W-1:0]   w_len_eff;
    logic        [LEN_W-1:0]   w_len_m1;
    logic                      w_last;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [OUT_W-1:0]   w_rq_data;
    logic                      w_rq_sat;

    // Handshake, last-beat detect and the sum that FLUSH registers.
    // A length of 0 wraps to all-ones in len-1, which makes it mean 2^LEN_W.
    always_comb begin
        w_in_ready = ((r_state == ST_IDLE) || (r_state == ST_ACCUM)) && !clear;
        w_accept   = in_valid && w_in_ready;
        w_clear    = clear && (r_state != ST_HOLD);
        w_len_eff  = (r_state == ST_IDLE) ? cfg_len : r_len;
        w_len_m1   = w_len_eff - LEN_W'(1);
        w_last     = (r_count == w_len_m1);
        w_prod_ext = ACC_W'(r_prod);
        w_sum      = r_acc + (r_prod_vld ? w_prod_ext : '0);
    end

    mac_requant #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_requant (
        .i_acc   (w_sum),
        .i_shift (r_shift),
        .i_relu  (r_relu),
        .o_data  (w_rq_data),
        .o_sat   (w_rq_sat)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear aborts everything except a pending result.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_last ? ST_FLUSH : ST_ACCUM;
            ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_clear) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Multiply/accumulate pipeline, config latch and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_len       <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_acc   <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_clear) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_prod_vld <= 1'b0;
        end else begin
            r_prod_vld <= w_accept;
            if (w_accept) begin
                r_prod  <= (2*DATA_W)'(in_a) * (2*DATA_W)'(in_b);
                r_count <= r_count + LEN_W'(1);
            end
            if (w_accept && (r_state == ST_IDLE)) begin
                r_len   <= cfg_len;
                r_shift <= cfg_shift;
                r_relu  <= cfg_relu;
            end
            if (r_state == ST_FLUSH) begin
                r_out_acc   <= w_sum;
                r_out_data  <= w_rq_data;
                r_out_sat   <= w_rq_sat;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_count     <= '0;
            end else if (r_prod_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end
            if ((r_state == ST_HOLD) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_acc   = r_out_acc;
    assign out_sat   = r_out_sat;
    assign busy      = (r_state != ST_IDLE);

endmodule
